// File: rtl/apu_dmc_pkg.sv
// Shared constants for the APU delta-modulation channel: rate period tables,
// register offsets and the register-file layout.
package apu_dmc_pkg;

  localparam logic [15:0] START_BASE = 16'hC000;

  localparam logic [1:0] REG_CTRL  = 2'd0;  // $4010
  localparam logic [1:0] REG_LEVEL = 2'd1;  // $4011
  localparam logic [1:0] REG_START = 2'd2;  // $4012
  localparam logic [1:0] REG_LEN   = 2'd3;  // $4013

  typedef logic [8:0] period_t;

  localparam period_t NTSC_PERIOD [16] = '{
    9'd428, 9'd380, 9'd340, 9'd320, 9'd286, 9'd254, 9'd226, 9'd214,
    9'd190, 9'd160, 9'd142, 9'd128, 9'd106, 9'd84,  9'd72,  9'd54
  };

  localparam period_t PAL_PERIOD [16] = '{
    9'd398, 9'd354, 9'd316, 9'd298, 9'd276, 9'd236, 9'd210, 9'd198,
    9'd176, 9'd148, 9'd132, 9'd118, 9'd98,  9'd78,  9'd66,  9'd50
  };

  typedef struct packed {
    logic       irq_en;
    logic       loop;
    logic [3:0] rate;
    logic [7:0] start;  // raw $4012 value
    logic [7:0] len;    // raw $4013 value
  } dmc_regs_t;

  function automatic period_t rate_period(input logic pal, input logic [3:0] rate);
    return pal ? PAL_PERIOD[rate] : NTSC_PERIOD[rate];
  endfunction

endpackage

// File: rtl/dmc_output_unit.sv
// DMC output unit: rate timer, 8-bit shifter, bit counter, silence flag and
// the 7-bit DAC level. Pulls a byte from the sample buffer at each byte boundary.
module dmc_output_unit
  import apu_dmc_pkg::*;
#(
  parameter bit PAL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ce_i,
  input  logic [3:0] rate_i,
  input  logic       lvl_wr_i,
  input  logic [6:0] lvl_din_i,
  input  logic       buf_full_i,
  input  logic [7:0] buf_data_i,
  output logic       buf_take_o,
  output logic [6:0] level_o
);

  logic [8:0] r_timer;
  logic [7:0] r_shift;
  logic [3:0] r_bits_rem;
  logic       r_silence;
  logic [6:0] r_level;

  logic       w_tick;
  logic       w_byte_end;
  logic [6:0] w_level_nxt;

  assign w_tick     = ce_i && (r_timer == 9'd0);
  assign w_byte_end = w_tick && (r_bits_rem == 4'd1);
  assign buf_take_o = w_byte_end && buf_full_i;
  assign level_o    = r_level;

  // Level saturates by holding rather than stepping past 0 or 127.
  always_comb begin
    w_level_nxt = r_level;
    if (!r_silence) begin
      if (r_shift[0] && (r_level <= 7'd125))
        w_level_nxt = r_level + 7'd2;
      else if (!r_shift[0] && (r_level >= 7'd2))
        w_level_nxt = r_level - 7'd2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_timer    <= rate_period(PAL, 4'd0) - 9'd1;
      r_shift    <= 8'd0;
      r_bits_rem <= 4'd8;
      r_silence  <= 1'b1;
      r_level    <= 7'd0;
    end else if (ce_i) begin
      if (r_timer == 9'd0)
        r_timer <= rate_period(PAL, rate_i) - 9'd1;
      else
        r_timer <= r_timer - 9'd1;

      if (w_tick) begin
        r_shift <= r_shift >> 1;
        if (w_byte_end) begin
          r_bits_rem <= 4'd8;
          if (buf_full_i) begin
            r_shift   <= buf_data_i;
            r_silence <= 1'b0;
          end else begin
            r_silence <= 1'b1;
          end
        end else begin
          r_bits_rem <= r_bits_rem - 4'd1;
        end
      end

      // A CPU write to $4011 overrides the output-unit step in the same cycle.
      if (lvl_wr_i)
        r_level <= lvl_din_i;
      else if (w_tick)
        r_level <= w_level_nxt;
    end
  end

endmodule

// File: rtl/dmc_sample_reader.sv
// APU DMC top: $4010-$4013 register file, sample fetch engine with the
// requesting side of the DMA handshake, IRQ flag, and the output unit.
module dmc_sample_reader
  import apu_dmc_pkg::*;
#(
  parameter bit PAL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ce_i,
  input  logic        reg_wr_i,
  input  logic [1:0]  reg_addr_i,
  input  logic [7:0]  reg_din_i,
  input  logic        en_wr_i,
  input  logic        en_val_i,
  output logic        dma_req_o,
  output logic [15:0] dma_addr_o,
  input  logic        dma_ack_i,
  input  logic [7:0]  dma_data_i,
  output logic [6:0]  level_o,
  output logic        active_o,
  output logic        irq_o
);

  dmc_regs_t   r_regs;
  logic [14:0] r_cur_addr;   // bit 15 of the fetch address is always 1
  logic [11:0] r_bytes_rem;
  logic [7:0]  r_buf;
  logic        r_full;
  logic        r_irq;

  logic        w_req;
  logic        w_ack;
  logic        w_take;
  logic        w_dis;
  logic        w_en_start;
  logic        w_last;
  logic        w_irq_set;
  logic        w_irq_clr;
  logic        w_lvl_wr;
  logic [14:0] w_start_addr;
  logic [11:0] w_length;

  assign w_start_addr = START_BASE[14:0] + {1'b0, r_regs.start, 6'b0};
  assign w_length     = {r_regs.len, 4'b0} + 12'd1;

  // DMA handshake: dma_req_o/dma_addr_o stay stable while the buffer is empty
  // and bytes remain; a ce cycle with dma_ack_i=1 while dma_req_o=1 transfers
  // dma_data_i and drops the request on that same edge. An ack without a
  // pending request is ignored; a disable write cancels the request.
  assign w_req      = !r_full && (r_bytes_rem != 12'd0);
  assign w_ack      = ce_i && dma_ack_i && w_req;
  assign w_dis      = ce_i && en_wr_i && !en_val_i;
  assign w_en_start = ce_i && en_wr_i && en_val_i && (r_bytes_rem == 12'd0);
  assign w_last     = (r_bytes_rem == 12'd1);
  assign w_irq_set  = w_ack && w_last && !r_regs.loop && r_regs.irq_en && !w_dis;
  assign w_irq_clr  = ce_i && (en_wr_i ||
                      (reg_wr_i && (reg_addr_i == REG_CTRL) && !reg_din_i[7]));
  assign w_lvl_wr   = ce_i && reg_wr_i && (reg_addr_i == REG_LEVEL);

  assign dma_req_o  = w_req;
  assign dma_addr_o = {1'b1, r_cur_addr};
  assign active_o   = (r_bytes_rem != 12'd0);
  assign irq_o      = r_irq;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_regs <= '0;
    end else if (ce_i && reg_wr_i) begin
      case (reg_addr_i)
        REG_CTRL: begin
          r_regs.irq_en <= reg_din_i[7];
          r_regs.loop   <= reg_din_i[6];
          r_regs.rate   <= reg_din_i[3:0];
        end
        REG_START: r_regs.start <= reg_din_i;
        REG_LEN:   r_regs.len   <= reg_din_i;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cur_addr  <= START_BASE[14:0];
      r_bytes_rem <= 12'd0;
    end else if (ce_i) begin
      // 15-bit increment wraps $FFFF to $8000 because bit 15 is implied.
      if (w_ack)
        r_cur_addr <= r_cur_addr + 15'd1;

      if (w_dis) begin
        r_bytes_rem <= 12'd0;
      end else if (w_en_start) begin
        r_cur_addr  <= w_start_addr;
        r_bytes_rem <= w_length;
      end else if (w_ack) begin
        if (w_last && r_regs.loop) begin
          r_cur_addr  <= w_start_addr;
          r_bytes_rem <= w_length;
        end else begin
          r_bytes_rem <= r_bytes_rem - 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_buf  <= 8'd0;
      r_full <= 1'b0;
      r_irq  <= 1'b0;
    end else if (ce_i) begin
      if (w_ack) begin
        r_buf  <= dma_data_i;
        r_full <= 1'b1;
      end else if (w_take) begin
        r_full <= 1'b0;
      end

      if (w_irq_clr)
        r_irq <= 1'b0;
      else if (w_irq_set)
        r_irq <= 1'b1;
    end
  end

  dmc_output_unit #(
    .PAL (PAL)
  ) u_output_unit (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .ce_i       (ce_i),
    .rate_i     (r_regs.rate),
    .lvl_wr_i   (w_lvl_wr),
    .lvl_din_i  (reg_din_i[6:0]),
    .buf_full_i (r_full),
    .buf_data_i (r_buf),
    .buf_take_o (w_take),
    .level_o    (level_o)
  );

endmodule

// File: tb/tb_dmc_sample_reader.sv
// Directed bench for dmc_sample_reader: register writes, DMA fetch sequencing,
// looping, IRQ behaviour, output level stepping and asynchronous reset.
module tb_dmc_sample_reader;
  import apu_dmc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ce_i = 1'b1;
  logic        reg_wr_i = 1'b0;
  logic [1:0]  reg_addr_i = 2'd0;
  logic [7:0]  reg_din_i = 8'd0;
  logic        en_wr_i = 1'b0;
  logic        en_val_i = 1'b0;
  logic        dma_req_o;
  logic [15:0] dma_addr_o;
  logic        dma_ack_i = 1'b0;
  logic [7:0]  dma_data_i = 8'd0;
  logic [6:0]  level_o;
  logic        active_o;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  dmc_sample_reader #(.PAL(1'b0)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .ce_i       (ce_i),
    .reg_wr_i   (reg_wr_i),
    .reg_addr_i (reg_addr_i),
    .reg_din_i  (reg_din_i),
    .en_wr_i    (en_wr_i),
    .en_val_i   (en_val_i),
    .dma_req_o  (dma_req_o),
    .dma_addr_o (dma_addr_o),
    .dma_ack_i  (dma_ack_i),
    .dma_data_i (dma_data_i),
    .level_o    (level_o),
    .active_o   (active_o),
    .irq_o      (irq_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    reg_wr_i = 1'b0; en_wr_i = 1'b0; dma_ack_i = 1'b0; ce_i = 1'b1;
    tick(3);
    rst_n_i = 1'b1;
    tick(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    reg_wr_i = 1'b1; reg_addr_i = a; reg_din_i = d;
    tick(1);
    reg_wr_i = 1'b0;
  endtask

  task automatic en_write(input logic v);
    en_wr_i = 1'b1; en_val_i = v;
    tick(1);
    en_wr_i = 1'b0;
  endtask

  task automatic dma_ack(input logic [7:0] d);
    dma_ack_i = 1'b1; dma_data_i = d;
    tick(1);
    dma_ack_i = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!dma_req_o && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, dma_req_o, 1);
  endtask

  initial begin
    logic [15:0] a;
    int n;

    // 1: reset state, single fetch with IRQ, $4010 clears IRQ
    do_reset();
    check("rst_req", dma_req_o, 0);
    check("rst_addr", dma_addr_o, 16'hC000);
    check("rst_level", level_o, 0);
    check("rst_active", active_o, 0);
    check("rst_irq", irq_o, 0);
    reg_write(REG_START, 8'h01);
    reg_write(REG_LEN, 8'h00);
    reg_write(REG_CTRL, 8'h80);
    en_write(1'b1);
    check("t1_req", dma_req_o, 1);
    check("t1_addr", dma_addr_o, 16'hC040);
    check("t1_active", active_o, 1);
    dma_ack(8'hAA);
    check("t1_req_drop", dma_req_o, 0);
    check("t1_active_end", active_o, 0);
    check("t1_irq", irq_o, 1);
    reg_write(REG_CTRL, 8'h80);
    check("t1_irq_keep", irq_o, 1);
    reg_write(REG_CTRL, 8'h00);
    check("t1_irq_clr4010", irq_o, 0);

    // 2: 65-byte sample crossing $FFFF -> $8000, stray ack ignored
    do_reset();
    reg_write(REG_CTRL, 8'h0F);
    reg_write(REG_START, 8'hFF);
    reg_write(REG_LEN, 8'h04);
    for (int i = 0; i < 65; i++)
      exp_q.push_back(i < 64 ? 16'hFFC0 + 16'(i) : 16'h8000);
    en_write(1'b1);
    for (int i = 0; i < 65; i++) begin
      wait_req("t2_req", 1000);
      a = exp_q.pop_front();
      check("t2_addr", dma_addr_o, a);
      dma_ack(8'($urandom_range(0, 255)));
      if (i == 0) begin
        check("t2_req_full", dma_req_o, 0);
        dma_ack(8'h5A);
      end
    end
    check("t2_active_end", active_o, 0);
    check("t2_irq_off", irq_o, 0);
    tick(1000);
    check("t2_idle", dma_req_o, 0);

    // 3: looping single-byte sample never ends and never raises IRQ
    do_reset();
    reg_write(REG_CTRL, 8'hCF);
    reg_write(REG_START, 8'h01);
    reg_write(REG_LEN, 8'h00);
    en_write(1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_req("t3_req", 1000);
      check("t3_addr", dma_addr_o, 16'hC040);
      dma_ack(8'h33);
      check("t3_active", active_o, 1);
      check("t3_irq", irq_o, 0);
    end

    // 3b: $4015 write clears IRQ and restarts an ended sample
    do_reset();
    reg_write(REG_CTRL, 8'h8F);
    en_write(1'b1);
    check("t3b_addr", dma_addr_o, 16'hC000);
    dma_ack(8'h00);
    check("t3b_irq", irq_o, 1);
    en_write(1'b1);
    check("t3b_irq_clr4015", irq_o, 0);
    check("t3b_restart", active_o, 1);

    // 4: level saturation at 126, stepping by 2 every 54 ce, floor at 1
    do_reset();
    reg_write(REG_CTRL, 8'h0F);
    reg_write(REG_LEVEL, 8'h7E);
    check("t4_lvl_write", level_o, 126);
    en_write(1'b1);
    dma_ack(8'hFF);
    tick(1500);
    check("t4_ceiling", level_o, 126);
    reg_write(REG_LEVEL, 8'h40);
    check("t4_lvl_64", level_o, 64);
    en_write(1'b1);
    wait_req("t4_req", 100);
    dma_ack(8'h00);
    n = 0;
    while (level_o == 7'd64 && n < 2000) begin
      tick(1);
      n++;
    end
    check("t4_step1", level_o, 62);
    tick(54);
    check("t4_step2", level_o, 60);
    tick(54 * 6);
    check("t4_level48", level_o, 48);
    tick(300);
    check("t4_hold48", level_o, 48);
    reg_write(REG_LEVEL, 8'h01);
    en_write(1'b1);
    wait_req("t4_req_floor", 100);
    dma_ack(8'h00);
    tick(2000);
    check("t4_floor", level_o, 1);

    // 5: ce gating, disable cancels request, disable with same-cycle ack
    do_reset();
    reg_write(REG_CTRL, 8'h8F);
    reg_write(REG_START, 8'h02);
    en_write(1'b1);
    check("t5_addr", dma_addr_o, 16'hC080);
    ce_i = 1'b0; dma_ack_i = 1'b1; dma_data_i = 8'h11;
    tick(3);
    dma_ack_i = 1'b0; ce_i = 1'b1;
    check("t5_noce_req", dma_req_o, 1);
    check("t5_noce_active", active_o, 1);
    en_write(1'b0);
    check("t5_dis_req", dma_req_o, 0);
    check("t5_dis_active", active_o, 0);
    check("t5_dis_irq", irq_o, 0);

    do_reset();
    reg_write(REG_CTRL, 8'h8F);
    reg_write(REG_LEVEL, 8'h40);
    en_write(1'b1);
    en_wr_i = 1'b1; en_val_i = 1'b0; dma_ack_i = 1'b1; dma_data_i = 8'h00;
    tick(1);
    en_wr_i = 1'b0; dma_ack_i = 1'b0;
    check("t5_ack_req", dma_req_o, 0);
    check("t5_ack_active", active_o, 0);
    check("t5_ack_irq", irq_o, 0);
    tick(2000);
    check("t5_ack_byte_used", level_o, 48);

    // 6: asynchronous reset mid-fetch
    do_reset();
    reg_write(REG_CTRL, 8'h8F);
    reg_write(REG_LEVEL, 8'h55);
    reg_write(REG_START, 8'h10);
    en_write(1'b1);
    check("t6_pre_req", dma_req_o, 1);
    #3 rst_n_i = 1'b0;
    #1;
    check("t6_req", dma_req_o, 0);
    check("t6_addr", dma_addr_o, 16'hC000);
    check("t6_level", level_o, 0);
    check("t6_active", active_o, 0);
    check("t6_irq", irq_o, 0);
    tick(2);
    rst_n_i = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
